// File: rtl/sram_post_neuron_ctl.sv
// -----------------------------------------------------------------------------
// sram_post_neuron_ctl
//
// Post-synaptic neuron state memory for the SNN forward/STDP datapath.
// Provides bit-masked single-port access with a one-cycle registered read and
// a hardware clear sequencer. The sequencer fills every word with CLR_VALUE
// after reset and on request.
//
// Parameters
//   ADDR_WIDTH  address bus width
//   DATA_WIDTH  word width (packed neuron state)
//   SRAM_DEPTH  number of words, SRAM_DEPTH <= 2**ADDR_WIDTH
//   CLR_VALUE   word written by the clear sequencer
//
// Ports
//   CK         clock, rising edge
//   RST        synchronous active-high reset
//   CLR_START  one-cycle request to re-clear the whole array (IDLE only)
//   CLR_BUSY   high while the clear sequencer owns the array (state bit)
//   CS         access request, accepted only in IDLE
//   WE         write enable, qualified by CS
//   A          word address; A >= SRAM_DEPTH drops writes, reads return 0
//   D          write data
//   BWE        per-bit write mask, 1 = bit takes D
//   Q          registered read data, holds when no access is accepted
//   Q_VALID    one-cycle pulse: Q carries the previous cycle's access
//
// Build option
//   SRAM_POST_NEURON_BYPASS_EN  defined: write-first, with a forwarding
//                               register for the previous cycle's write.
//                               undefined: read-first (pre-write data on Q).
// -----------------------------------------------------------------------------
module sram_post_neuron_ctl #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    SRAM_DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                  CK,
   input  logic                  RST,
   input  logic                  CLR_START,
   output logic                  CLR_BUSY,
   input  logic                  CS,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] BWE,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  Q_VALID
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);
   // One extra bit so the range check stays meaningful when the array
   // fills the whole address space.
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(SRAM_DEPTH);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   q_q, q_d;
   logic                    q_valid_q, q_valid_d;

   (* ram_style = "distributed" *)
   logic [DATA_WIDTH-1:0]   mem [SRAM_DEPTH];

   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   logic                    in_range;
   logic [DATA_WIDTH-1:0]   rd_word;   // current contents of word[A]
   logic [DATA_WIDTH-1:0]   merged;    // word[A] after the masked write
   logic [DATA_WIDTH-1:0]   rd_ret;    // value an accepted access returns

   assign in_range = ({1'b0, A} < DEPTH_W);
   assign merged   = (rd_word & ~BWE) | (D & BWE);

`ifdef SRAM_POST_NEURON_BYPASS_EN
   // Forwarding register: the last accepted in-range write. A read of that
   // address on the following cycle takes the forwarded word, so the result
   // does not depend on how the array mapping orders read and write.
   logic                  fwd_vld_q, fwd_vld_d;
   logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
   logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

   always_comb begin
      fwd_vld_d  = (state_q == IDLE) && CS && WE && in_range;
      fwd_addr_d = A;
      fwd_data_d = merged;
      if (fwd_vld_q && (fwd_addr_q == A)) begin
         rd_word = fwd_data_q;
      end else begin
         rd_word = mem[A];
      end
      // Write-first: a write returns the merged new word.
      rd_ret = WE ? merged : rd_word;
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         fwd_vld_q  <= 1'b0;
         fwd_addr_q <= '0;
         fwd_data_q <= '0;
      end else begin
         fwd_vld_q  <= fwd_vld_d;
         fwd_addr_q <= fwd_addr_d;
         fwd_data_q <= fwd_data_d;
      end
   end
`else
   always_comb begin
      rd_word = mem[A];
      // Read-first: pre-write contents are returned even on a write.
      rd_ret  = rd_word;
   end
`endif

   // Next-state, access and array-write decode.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      // NOTE: combinational logic uses blocking '='; only the clocked
      // processes below use non-blocking '<='.
      state_d   = state_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      q_valid_d = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = A;
      mem_wdata = merged;

      unique case (state_q)
         CLEAR: begin
            // The sequencer owns the array: CS and CLR_START are ignored.
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLR_VALUE;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            if (CLR_START) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
            // An access in the CLR_START cycle is still served.
            if (CS) begin
               q_valid_d = 1'b1;
               q_d       = in_range ? rd_ret : '0;
               mem_we    = WE && in_range;
            end
         end
         default: state_d = CLEAR;
      endcase

      // Nothing reaches the array in a reset cycle.
      if (RST) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

   // NOTE: the array itself has no reset; the clear sequencer initialises it
   // after reset, which keeps it mappable onto distributed RAM.
   always_ff @(posedge CK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign CLR_BUSY = (state_q == CLEAR);
   assign Q        = q_q;
   assign Q_VALID  = q_valid_q;

endmodule

// File: tb/tb_sram_post_neuron_ctl.sv
// -----------------------------------------------------------------------------
// tb_sram_post_neuron_ctl
//
// Directed bench for sram_post_neuron_ctl. It instantiates two copies:
//   dut_a : default build (256 words, clear value 0)
//   dut_b : 200 words, clear value 0xA5A5A5A5 (out-of-range and re-clear)
// A per-instance memory model gives the expected read data. The expected
// value is pushed when an access is driven, and popped when Q_VALID fires.
// -----------------------------------------------------------------------------
module tb_sram_post_neuron_ctl;

   logic        ck = 1'b0;
   logic        rst;
   logic        clr [2];
   logic        cs  [2];
   logic        we  [2];
   logic [7:0]  a   [2];
   logic [31:0] d   [2];
   logic [31:0] bwe [2];
   logic        busy[2];
   logic [31:0] q   [2];
   logic        qv  [2];

   always #5 ck = ~ck;

   sram_post_neuron_ctl dut_a (
      .CK(ck), .RST(rst), .CLR_START(clr[0]), .CLR_BUSY(busy[0]),
      .CS(cs[0]), .WE(we[0]), .A(a[0]), .D(d[0]), .BWE(bwe[0]),
      .Q(q[0]), .Q_VALID(qv[0])
   );

   sram_post_neuron_ctl #(
      .SRAM_DEPTH(200),
      .CLR_VALUE (32'hA5A5_A5A5)
   ) dut_b (
      .CK(ck), .RST(rst), .CLR_START(clr[1]), .CLR_BUSY(busy[1]),
      .CS(cs[1]), .WE(we[1]), .A(a[1]), .D(d[1]), .BWE(bwe[1]),
      .Q(q[1]), .Q_VALID(qv[1])
   );

   logic [31:0] mdl [2][256];
   int          depth [2] = '{256, 200};
   logic [31:0] clrv  [2] = '{32'h0000_0000, 32'hA5A5_A5A5};
   logic [31:0] last_q[2];
   logic [31:0] sb [$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic fill(input int s);
      for (int i = 0; i < depth[s]; i++) mdl[s][i] = clrv[s];
   endtask

   // One clock of stimulus on instance s. exp_acc says whether the bench
   // expects the access to be accepted (IDLE and CS).
   task automatic step(input string tag, input int s, input bit exp_acc,
                       input logic c, input logic w, input logic [7:0] ad,
                       input logic [31:0] dd, input logic [31:0] bb,
                       input logic cl);
      logic [31:0] old_w, new_w, exp_q;
      bit          inr;
      cs[s] = c; we[s] = w; a[s] = ad; d[s] = dd; bwe[s] = bb; clr[s] = cl;
      if (exp_acc) begin
         inr   = (int'(ad) < depth[s]);
         old_w = inr ? mdl[s][ad] : 32'h0;
         new_w = (old_w & ~bb) | (dd & bb);
`ifdef SRAM_POST_NEURON_BYPASS_EN
         exp_q = (inr && w) ? new_w : old_w;
`else
         exp_q = old_w;
`endif
         sb.push_back(exp_q);
         if (w && inr) mdl[s][ad] = new_w;
      end
      tick();
      cs[s] = 1'b0; we[s] = 1'b0; clr[s] = 1'b0;
      if (sb.size() > 0) begin
         check({tag, ".qv"}, 32'(qv[s]), 32'd1);
         exp_q = sb.pop_front();
         check({tag, ".q"}, q[s], exp_q);
         last_q[s] = exp_q;
      end else begin
         check({tag, ".qv"}, 32'(qv[s]), 32'd0);
         check({tag, ".qhold"}, q[s], last_q[s]);
      end
   endtask

   // Ticks until CLR_BUSY of instance s drops (bounded) and checks the count.
   task automatic wait_clear(input string tag, input int s, input int exp_n);
      int n = 0;
      while (busy[s] === 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'(exp_n));
      fill(s);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         clr[s] = 1'b0; cs[s] = 1'b0; we[s] = 1'b0;
         a[s] = '0; d[s] = '0; bwe[s] = '0; last_q[s] = '0;
      end

      // Reset for three cycles.
      rst = 1'b1;
      repeat (3) tick();
      check("rst.busy_a", 32'(busy[0]), 32'd1);
      check("rst.busy_b", 32'(busy[1]), 32'd1);
      check("rst.q_a",    q[0], 32'h0);
      check("rst.qv_a",   32'(qv[0]), 32'd0);
      rst = 1'b0;

      // Power-up clear: exactly 256 busy cycles on the default instance.
      wait_clear("init.busy_cycles_a", 0, 256);
      check("init.busy_b_done", 32'(busy[1]), 32'd0);
      fill(1);

      // First reads, back to back, then an idle cycle.
      step("rd0",   0, 1, 1, 0, 8'd0,   '0, '0, 0);
      step("rd128", 0, 1, 1, 0, 8'd128, '0, '0, 0);
      step("rd255", 0, 1, 1, 0, 8'd255, '0, '0, 0);
      step("idle0", 0, 0, 0, 0, 8'd0,   '0, '0, 0);

      // Masked write over a cleared word.
      step("mw5",   0, 1, 1, 1, 8'd5, 32'hFFFF_FFFF, 32'h0000_FF00, 0);
      step("rd5",   0, 1, 1, 0, 8'd5, '0, '0, 0);
      check("rd5.value", last_q[0], 32'h0000_FF00);

      // Same-address write after write, then read.
      step("w7a",   0, 1, 1, 1, 8'd7, 32'h1111_1111, 32'hFFFF_FFFF, 0);
      step("w7b",   0, 1, 1, 1, 8'd7, 32'h2222_2222, 32'hFFFF_FFFF, 0);
`ifdef SRAM_POST_NEURON_BYPASS_EN
      check("w7b.value", last_q[0], 32'h2222_2222);
`else
      check("w7b.value", last_q[0], 32'h1111_1111);
`endif
      step("rd7",   0, 1, 1, 0, 8'd7, '0, '0, 0);
      check("rd7.value", last_q[0], 32'h2222_2222);
      step("idle1", 0, 0, 0, 0, 8'd0, '0, '0, 0);

      // Out of range on the 200-word instance.
      step("oor_w", 1, 1, 1, 1, 8'd250, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
      step("oor_r", 1, 1, 1, 0, 8'd250, '0, '0, 0);
      check("oor_r.value", last_q[1], 32'h0);
      for (int i = 0; i < 200; i++)
         step($sformatf("b_scan%0d", i), 1, 1, 1, 0, 8'(i), '0, '0, 0);

      // Dirty two words, then re-clear with a read in the CLR_START cycle.
      step("b_mw10",  1, 1, 1, 1, 8'd10,  32'h0000_0000, 32'h0000_FFFF, 0);
      step("b_w199",  1, 1, 1, 1, 8'd199, 32'h1234_5678, 32'hFFFF_FFFF, 0);
      step("b_clr",   1, 1, 1, 0, 8'd10,  '0, '0, 1);
      check("b_clr.value", last_q[1], 32'hA5A5_0000);
      check("b_clr.busy",  32'(busy[1]), 32'd1);
      // Accesses and CLR_START during the clear are ignored.
      step("b_busy0", 1, 0, 1, 1, 8'd10,  32'h0, 32'hFFFF_FFFF, 0);
      step("b_busy1", 1, 0, 1, 0, 8'd20,  32'h0, 32'h0, 1);
      step("b_busy2", 1, 0, 1, 1, 8'd199, 32'h0, 32'hFFFF_FFFF, 0);
      wait_clear("b_clr.busy_cycles", 1, 197);
      for (int i = 0; i < 200; i++)
         step($sformatf("b_post%0d", i), 1, 1, 1, 0, 8'(i), '0, '0, 0);
      check("b_post.last", last_q[1], 32'hA5A5_A5A5);

      // Re-clear of the default instance, reset at clear cycle 100.
      step("a_clr", 0, 0, 0, 0, 8'd0, '0, '0, 1);
      repeat (100) tick();
      check("a_mid.busy",  32'(busy[0]), 32'd1);
      check("a_mid.qhold", q[0], 32'h2222_2222);
      rst = 1'b1;
      tick();
      check("a_rst.q",    q[0], 32'h0);
      check("a_rst.qv",   32'(qv[0]), 32'd0);
      check("a_rst.busy", 32'(busy[0]), 32'd1);
      rst = 1'b0;
      last_q[0] = '0;
      last_q[1] = '0;
      wait_clear("a_rst.busy_cycles", 0, 256);
      check("a_rst.busy_b", 32'(busy[1]), 32'd0);
      fill(1);
      step("a_rd7",   0, 1, 1, 0, 8'd7,   '0, '0, 0);
      step("a_rd5",   0, 1, 1, 0, 8'd5,   '0, '0, 0);
      step("a_rd255", 0, 1, 1, 0, 8'd255, '0, '0, 0);
      step("b_rd10",  1, 1, 1, 0, 8'd10,  '0, '0, 0);
      check("b_rd10.value", last_q[1], 32'hA5A5_A5A5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
